fifo_out_packer: RTL and testbench
==================================

// Module: fifo_out_packer
// PURPOSE
//  Downstream drain stage for the single-port RAM FIFO. Pops WID-bit words via the FIFO's
//  readout/empty/dataout interface and packs PACK words into one wide beat on a valid/ready
//  output. A partial beat is emitted on an explicit flush or after TIMEOUT idle cycles.
//  It sits between the RAM FIFO and a wide bus or DMA writer.
// PARAMETERS
//  WID      32  word width; matches the FIFO data width
//  PACK     4   words per output beat (>=2)
//  TIMEOUT  64  idle cycles with a partial beat before auto-flush; 0 disables the timeout
//  WN       $clog2(PACK+1)  width of the word-count fields
// PORTS
//  clk        in   1         clock; single clock domain
//  rst_n      in   1         asynchronous reset, active-low
//  softreset  in   1         synchronous clear, same effect as reset
//  empty      in   1         FIFO empty
//  dataout    in   WID       FIFO head word; valid when !empty
//  readout    out  1         pop strobe to the FIFO (combinational)
//  flush      in   1         level; emit the partial beat now
//  vout       out  1         output beat valid
//  ready      in   1         downstream accepts the beat when vout&&ready
//  dout       out  WID*PACK  packed beat; lane i = dout[i*WID +: WID], first word in lane 0
//  nwords     out  WN        number of valid lanes in dout (1..PACK)
//  busy       out  1         wcnt!=0 || vout
// BEHAVIOUR
//  - Reset/softreset: vout=0, dout=0, nwords=0, wcnt=0, idle_cnt=0, state=EMPTY; readout=0 that cycle.
//  - Accumulator acc[PACK] with fill count wcnt. Output register holds one beat.
//  - slot_free = !vout || ready.
//  - readout = !empty && !flush && !softreset && (wcnt<PACK || slot_free).
//    Each pop writes dataout into acc lane wcnt.
//  - FSM states (derived from wcnt): EMPTY (wcnt==0), FILLING (0<wcnt<PACK), FULLW (wcnt==PACK).
//  - emit = slot_free && (wcnt==PACK || (wcnt>0 && flush) || (TIMEOUT!=0 && wcnt>0 && idle_cnt==TIMEOUT)).
//  - On emit, next cycle: vout=1, dout=acc with lanes >=wcnt driven to 0, nwords=wcnt.
//  - Emit in FULLW with a simultaneous pop: the popped word goes to lane 0, wcnt=1,
//    sustaining 1 word/cycle. Any other emit leaves wcnt=0.
//  - vout&&ready without a new emit: vout=0 next cycle. dout/nwords are held stable while vout&&!ready.
//  - Latency: the pop of lane PACK-1 at cycle t gives vout at t+2, given slot_free.
//  - Steady-state throughput: PACK words per PACK cycles when ready=1.
//  - idle_cnt (width $clog2(TIMEOUT+1)) increments when wcnt>0 && no pop && no emit, and saturates at TIMEOUT.
//    It clears on any pop or emit.
//  - flush with wcnt==0: no beat is emitted (a zero-word beat is never produced).
//  - flush while vout&&!ready: the emit waits for slot_free; pops stay blocked while flush=1.
//  - empty toggling mid-beat is legal; the partial beat is held until full, flush or timeout.
//  - Reset mid-beat discards acc contents; the FIFO is not notified.
// STRUCTURE
//  - Shared package fifo_pkg: packer state encoding (EMPTY/FILLING/FULLW) and a lane-slice helper function.
//  - No sub-module: accumulator, idle timer and output register stay in one module (~200 lines).
// TESTING
//  1. PACK=4: push words 1,2,3,4 with ready=1 -> one beat dout={4,3,2,1}, nwords=4, vout at pop4+2.
//  2. Stream 12 words back-to-back with ready=1 -> 3 beats on consecutive-4 cycle spacing;
//     readout never drops for a FULLW stall.
//  3. Push 2 words, raise flush for 1 cycle -> beat {0,0,w2,w1}, nwords=2; readout=0 during flush.
//  4. TIMEOUT=8: push 3 words, then empty=1 -> beat with nwords=3 emitted 8 idle cycles after the last pop.
//  5. Hold ready=0 with a full beat pending and acc full -> readout=0 and dout stable.
//     Release ready -> next beat follows next cycle, no word lost or reordered.
//  6. Assert rst_n=0, then softreset, each mid-beat with 3 words held -> vout=0, busy=0;
//     the next beat starts in lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared packer state encoding and lane helpers
package fifo_pkg;

    // Packer fill state, always a pure function of the word count.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULLW   = 2'd2
    } pack_state_t;

    // Classify a fill count against the beat size.
    function automatic pack_state_t state_of(input int unsigned cnt, input int unsigned pack);
        if (cnt == 0)
            return ST_EMPTY;
        else if (cnt >= pack)
            return ST_FULLW;
        else
            return ST_FILLING;
    endfunction

    // A lane carries data only if it lies below the fill count.
    function automatic logic lane_live(input int unsigned lane, input int unsigned cnt);
        return lane < cnt;
    endfunction

endpackage

// File: rtl/fifo_out_packer.sv
// rtl/fifo_out_packer.sv - drains the RAM FIFO and packs PACK words per output beat
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   softreset       synchronous clear, same effect as rst_n
//   empty, dataout  FIFO head status and word
//   readout         pop strobe to the FIFO (combinational)
//   flush           level; emit the partial beat now
//   vout, ready     output beat handshake
//   dout, nwords    packed beat (lane 0 = first word) and its valid lane count
//   busy            words held in the accumulator or a beat pending
module fifo_out_packer
    import fifo_pkg::*;
#(
    parameter int WID     = 32,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 64,
    parameter int WN      = $clog2(PACK + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                softreset,
    input  logic                empty,
    input  logic [WID-1:0]      dataout,
    output logic                readout,
    input  logic                flush,
    output logic                vout,
    input  logic                ready,
    output logic [WID*PACK-1:0] dout,
    output logic [WN-1:0]       nwords,
    output logic                busy
);

    // Keep the idle counter at least one bit wide when the timeout is disabled.
    localparam int             IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0]  TMO_W = IW'(TIMEOUT);

    logic [WID-1:0]      acc [PACK];
    logic [WN-1:0]       wcnt;
    logic [WN-1:0]       wcnt_nx;
    logic [WN-1:0]       pop_lane;
    logic [IW-1:0]       idle_cnt;
    pack_state_t         state;
    logic                slot_free;
    logic                full;
    logic                has_data;
    logic                timeout_hit;
    logic                emit;
    logic [WID*PACK-1:0] beat;

    assign slot_free   = !vout || ready;
    assign full        = (state == ST_FULLW);
    assign has_data    = (state != ST_EMPTY);
    assign timeout_hit = (TIMEOUT != 0) && has_data && (idle_cnt == TMO_W);
    assign emit        = slot_free && (full || (has_data && flush) || timeout_hit);

    // A full accumulator may only take a word when the beat leaves this cycle.
    assign readout = rst_n && !empty && !flush && !softreset && (!full || slot_free);

    assign busy = (wcnt != '0) || vout;

    // On emit the accumulator restarts, so a concurrent pop lands in lane 0.
    always_comb begin
        pop_lane = emit ? '0 : wcnt;
        if (emit)
            wcnt_nx = readout ? WN'(1) : '0;
        else
            wcnt_nx = readout ? wcnt + WN'(1) : wcnt;
    end

    // Unfilled lanes go out as zero rather than stale data from earlier beats.
    always_comb begin
        beat = '0;
        for (int i = 0; i < PACK; i++) begin
            if (lane_live(i, 32'(wcnt)))
                beat[i*WID +: WID] = acc[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PACK; i++)
                acc[i] <= '0;
            wcnt     <= '0;
            idle_cnt <= '0;
            state    <= ST_EMPTY;
            vout     <= 1'b0;
            dout     <= '0;
            nwords   <= '0;
        end else if (softreset) begin
            for (int i = 0; i < PACK; i++)
                acc[i] <= '0;
            wcnt     <= '0;
            idle_cnt <= '0;
            state    <= ST_EMPTY;
            vout     <= 1'b0;
            dout     <= '0;
            nwords   <= '0;
        end else begin
            for (int i = 0; i < PACK; i++) begin
                if (readout && (pop_lane == WN'(i)))
                    acc[i] <= dataout;
            end
            wcnt  <= wcnt_nx;
            state <= state_of(32'(wcnt_nx), PACK);

            if (emit) begin
                vout   <= 1'b1;
                dout   <= beat;
                nwords <= wcnt;
            end else if (ready) begin
                vout <= 1'b0;
            end

            // Idle timer only runs while a partial beat sits with nothing happening.
            if (readout || emit || !has_data)
                idle_cnt <= '0;
            else if ((TIMEOUT != 0) && (idle_cnt != TMO_W))
                idle_cnt <= idle_cnt + IW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_out_packer.sv
// tb/tb_fifo_out_packer.sv - directed self-checking bench for fifo_out_packer
module tb_fifo_out_packer;

    localparam int WID  = 32;
    localparam int PACK = 4;
    localparam int TMO  = 8;
    localparam int WN   = $clog2(PACK + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                softreset = 1'b0;
    logic                empty;
    logic [WID-1:0]      dataout;
    logic                readout;
    logic                flush = 1'b0;
    logic                vout;
    logic                ready = 1'b1;
    logic [WID*PACK-1:0] dout;
    logic [WN-1:0]       nwords;
    logic                busy;

    fifo_out_packer #(.WID(WID), .PACK(PACK), .TIMEOUT(TMO), .WN(WN)) dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset), .empty(empty),
        .dataout(dataout), .readout(readout), .flush(flush), .vout(vout),
        .ready(ready), .dout(dout), .nwords(nwords), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: words pushed at tail, popped at head on readout.
    logic [WID-1:0] mem [64];
    int             pop_cyc [64];
    int             head = 0;
    int             tail = 0;
    int             cyc = 0;

    typedef struct {
        logic [WID*PACK-1:0] d;
        int                  n;
        int                  c;
    } beat_t;
    beat_t beats [$];

    assign empty   = (head >= tail);
    assign dataout = mem[head[5:0]];

    always @(posedge clk) begin
        if (readout) begin
            pop_cyc[head[5:0]] <= cyc;
            head <= head + 1;
        end
        if (vout && ready)
            beats.push_back('{d: dout, n: int'(nwords), c: cyc});
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push(input logic [31:0] w);
        mem[tail[5:0]] = w;
        tail = tail + 1;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int budget;
        budget = 200;
        while (beats.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (beats.size() < n)
            check({tag, "_timeout"}, 128'(beats.size()), 128'(n));
    endtask

    task automatic wait_drained(input string tag);
        int budget;
        budget = 200;
        while (head < tail && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (head < tail)
            check({tag, "_drain_timeout"}, 128'(head), 128'(tail));
    endtask

    int bi;
    int base;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vout", 128'(vout), 128'(0));
        check("rst_nwords", 128'(nwords), 128'(0));
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single full beat and latency
        bi = beats.size();
        base = tail;
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        wait_beats(bi + 1, "t1");
        check("t1_dout", beats[bi].d, pk4(32'd1, 32'd2, 32'd3, 32'd4));
        check("t1_nwords", 128'(beats[bi].n), 128'(4));
        check("t1_latency", 128'(beats[bi].c - pop_cyc[base + 3]), 128'(2));

        // 2: 12 words back-to-back
        @(negedge clk);
        bi = beats.size();
        base = tail;
        for (int i = 0; i < 12; i++)
            push(32'h10 + 32'(i));
        wait_beats(bi + 3, "t2");
        check("t2_pop_span", 128'(pop_cyc[base + 11] - pop_cyc[base]), 128'(11));
        check("t2_beat0", beats[bi].d, pk4(32'h10, 32'h11, 32'h12, 32'h13));
        check("t2_beat2", beats[bi + 2].d, pk4(32'h18, 32'h19, 32'h1a, 32'h1b));
        check("t2_space01", 128'(beats[bi + 1].c - beats[bi].c), 128'(4));
        check("t2_space12", 128'(beats[bi + 2].c - beats[bi + 1].c), 128'(4));

        // 3: flush of a partial beat, pops blocked while flush is high
        @(negedge clk);
        bi = beats.size();
        push(32'hA1); push(32'hA2);
        wait_drained("t3");
        flush = 1'b1;
        push(32'hA3);
        #1 check("t3_readout_flush", 128'(readout), 128'(0));
        @(negedge clk);
        flush = 1'b0;
        wait_beats(bi + 1, "t3");
        check("t3_dout", beats[bi].d, pk4(32'hA1, 32'hA2, 32'h0, 32'h0));
        check("t3_nwords", 128'(beats[bi].n), 128'(2));
        wait_drained("t3b");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_beats(bi + 2, "t3b");
        check("t3_lone", beats[bi + 1].d, pk4(32'hA3, 32'h0, 32'h0, 32'h0));
        check("t3_lone_n", 128'(beats[bi + 1].n), 128'(1));

        // flush with nothing accumulated emits nothing
        @(negedge clk);
        bi = beats.size();
        flush = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_empty_nobeat", 128'(beats.size()), 128'(bi));
        check("flush_empty_vout", 128'(vout), 128'(0));

        // 4: timeout auto-flush
        bi = beats.size();
        base = tail;
        push(32'hB1); push(32'hB2); push(32'hB3);
        wait_beats(bi + 1, "t4");
        check("t4_dout", beats[bi].d, pk4(32'hB1, 32'hB2, 32'hB3, 32'h0));
        check("t4_nwords", 128'(beats[bi].n), 128'(3));
        check("t4_delay", 128'(beats[bi].c - pop_cyc[base + 2]), 128'(10));

        // 5: backpressure with a full beat pending and acc full
        @(negedge clk);
        bi = beats.size();
        ready = 1'b0;
        for (int i = 0; i < 9; i++)
            push(32'hC0 + 32'(i));
        repeat (12) @(negedge clk);
        check("t5_readout_stall", 128'(readout), 128'(0));
        check("t5_vout_held", 128'(vout), 128'(1));
        check("t5_dout_held", dout, pk4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        repeat (3) @(negedge clk);
        check("t5_dout_stable", dout, pk4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        check("t5_nwords_held", 128'(nwords), 128'(4));
        ready = 1'b1;
        wait_beats(bi + 2, "t5");
        check("t5_beat1", beats[bi].d, pk4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        check("t5_beat2", beats[bi + 1].d, pk4(32'hC4, 32'hC5, 32'hC6, 32'hC7));
        check("t5_back2back", 128'(beats[bi + 1].c - beats[bi].c), 128'(1));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_beats(bi + 3, "t5c");
        check("t5_tail", beats[bi + 2].d, pk4(32'hC8, 32'h0, 32'h0, 32'h0));

        // 6a: asynchronous reset mid-beat
        @(negedge clk);
        bi = beats.size();
        push(32'hD1); push(32'hD2); push(32'hD3);
        wait_drained("t6a");
        rst_n = 1'b0;
        push(32'hD4);
        #1;
        check("t6a_vout", 128'(vout), 128'(0));
        check("t6a_busy", 128'(busy), 128'(0));
        check("t6a_readout", 128'(readout), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(32'hE2); push(32'hE3); push(32'hE4);
        wait_beats(bi + 1, "t6a");
        check("t6a_beat", beats[bi].d, pk4(32'hD4, 32'hE2, 32'hE3, 32'hE4));

        // 6b: softreset mid-beat
        @(negedge clk);
        bi = beats.size();
        push(32'hF1); push(32'hF2); push(32'hF3);
        wait_drained("t6b");
        softreset = 1'b1;
        push(32'hF4);
        #1 check("t6b_readout", 128'(readout), 128'(0));
        @(negedge clk);
        check("t6b_vout", 128'(vout), 128'(0));
        check("t6b_busy", 128'(busy), 128'(0));
        softreset = 1'b0;
        push(32'hB5); push(32'hB6); push(32'hB7);
        wait_beats(bi + 1, "t6b");
        check("t6b_beat", beats[bi].d, pk4(32'hF4, 32'hB5, 32'hB6, 32'hB7));
        check("t6b_nwords", 128'(beats[bi].n), 128'(4));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
